// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: serves core fetches from an on-chip array filled by a valid/ready loader.
// Define INST_MEM_BYTE_LOAD_EN for an 8-bit loader port that assembles big-endian words from byte beats.
module inst_mem_resp #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rom_en,
   input  logic [31:0] i_rom_addr,
   output logic [31:0] o_rom_data,
   input  logic        i_ld_start,
   input  logic        i_ld_valid,
`ifdef INST_MEM_BYTE_LOAD_EN
   input  logic [7:0]  i_ld_data,
`else
   input  logic [31:0] i_ld_data,
`endif
   input  logic        i_ld_last,
   output logic        o_ld_ready,
   output logic        o_ld_done,
   output logic        o_cpu_hold,
   output logic        o_ld_ovf,
   output logic        o_fetch_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t                r_state, w_state_nx;
   logic [DEPTH_LOG2-1:0] r_wptr, w_wptr_nx;
   logic                  r_ld_ready, w_ld_ready_nx;
   logic                  r_ld_done, w_ld_done_nx;
   logic                  r_cpu_hold, w_cpu_hold_nx;
   logic                  r_ld_ovf, w_ld_ovf_nx;
   logic                  r_fetch_err, w_fetch_err_nx;

   logic [31:0]           r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_we;
   logic [31:0]           w_wdata;

   logic [31:0]           w_off;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_misal;
   logic                  w_oor;
   logic                  w_hit;

   // A restart beat is never written, even when valid is high alongside ld_start.
   assign w_accept = (r_state == S_LOAD) & r_ld_ready & i_ld_valid & ~i_ld_start;

`ifdef INST_MEM_BYTE_LOAD_EN
   logic [1:0]  r_lane;
   logic [23:0] r_acc;

   // r_acc holds the bytes already received, left-justified, so the partial word is always ready.
   always_comb begin
      w_wdata = 32'h0;
      case (r_lane)
         2'd0:    w_wdata = {i_ld_data, 24'h0};
         2'd1:    w_wdata = {r_acc[23:16], i_ld_data, 16'h0};
         2'd2:    w_wdata = {r_acc[23:8], i_ld_data, 8'h0};
         default: w_wdata = {r_acc, i_ld_data};
      endcase
   end

   assign w_we = w_accept & ((r_lane == 2'd3) | i_ld_last);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_ld_start) begin
         r_lane <= 2'd0;
         r_acc  <= 24'h0;
      end else if (w_accept) begin
         r_lane <= w_we ? 2'd0 : r_lane + 2'd1;
         r_acc  <= w_we ? 24'h0 : w_wdata[31:8];
      end
   end
`else
   assign w_wdata = i_ld_data;
   assign w_we    = w_accept;
`endif

   // Fetch decode; an address below BASE_ADDR wraps high and reads as out of range.
   assign w_off   = i_rom_addr - BASE_ADDR;
   assign w_idx   = w_off[DEPTH_LOG2+1:2];
   assign w_misal = |i_rom_addr[1:0];
   assign w_oor   = |(w_off >> (DEPTH_LOG2 + 2));
   assign w_hit   = (r_state == S_RUN) & i_rom_en & ~w_misal & ~w_oor;

   assign o_rom_data = w_hit ? r_mem[w_idx] : 32'h0;

   always_comb begin
      w_state_nx     = r_state;
      w_wptr_nx      = r_wptr;
      w_ld_done_nx   = 1'b0;
      w_ld_ovf_nx    = r_ld_ovf;
      w_fetch_err_nx = r_fetch_err;
      case (r_state)
         S_IDLE: begin
            if (i_ld_start) begin
               w_state_nx     = S_LOAD;
               w_wptr_nx      = '0;
               w_ld_ovf_nx    = 1'b0;
               w_fetch_err_nx = 1'b0;
            end
         end
         S_LOAD: begin
            if (i_ld_start) begin
               w_wptr_nx      = '0;
               w_ld_ovf_nx    = 1'b0;
               w_fetch_err_nx = 1'b0;
            end else begin
               if (w_we) begin
                  w_wptr_nx = r_wptr + DEPTH_LOG2'(1);
                  if (&r_wptr) w_ld_ovf_nx = 1'b1;
               end
               if (w_accept && i_ld_last) begin
                  w_state_nx   = S_RUN;
                  w_ld_done_nx = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (i_ld_start) begin
               w_state_nx     = S_LOAD;
               w_wptr_nx      = '0;
               w_ld_ovf_nx    = 1'b0;
               w_fetch_err_nx = 1'b0;
            end else if (i_rom_en && (w_misal || w_oor)) begin
               w_fetch_err_nx = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      w_ld_ready_nx = (w_state_nx == S_LOAD);
      w_cpu_hold_nx = (w_state_nx != S_RUN);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_wptr      <= '0;
         r_ld_ready  <= 1'b0;
         r_ld_done   <= 1'b0;
         r_cpu_hold  <= 1'b1;
         r_ld_ovf    <= 1'b0;
         r_fetch_err <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_wptr      <= w_wptr_nx;
         r_ld_ready  <= w_ld_ready_nx;
         r_ld_done   <= w_ld_done_nx;
         r_cpu_hold  <= w_cpu_hold_nx;
         r_ld_ovf    <= w_ld_ovf_nx;
         r_fetch_err <= w_fetch_err_nx;
      end
   end

   // Array is deliberately not reset; a reset cycle only suppresses the write.
   always_ff @(posedge i_clk) begin
      if (w_we && !i_rst) r_mem[r_wptr] <= w_wdata;
   end

   assign o_ld_ready  = r_ld_ready;
   assign o_ld_done   = r_ld_done;
   assign o_cpu_hold  = r_cpu_hold;
   assign o_ld_ovf    = r_ld_ovf;
   assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: two instances (1024 words @0, 4 words @0x100) share one stimulus.
`timescale 1ns/1ps
module tb_inst_mem_resp;
`ifdef INST_MEM_BYTE_LOAD_EN
   localparam int LW = 8;
`else
   localparam int LW = 32;
`endif

   logic          clk = 1'b0;
   logic          rst, rom_en, ld_start, ld_valid, ld_last;
   logic [31:0]   rom_addr;
   logic [LW-1:0] ld_data;
   logic [31:0]   data_a, data_b;
   logic          rdy_a, done_a, hold_a, ovf_a, ferr_a;
   logic          rdy_b, done_b, hold_b, ovf_b, ferr_b;

   always #5 clk = ~clk;

   inst_mem_resp #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0)) u_a (
      .i_clk(clk), .i_rst(rst), .i_rom_en(rom_en), .i_rom_addr(rom_addr), .o_rom_data(data_a),
      .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last),
      .o_ld_ready(rdy_a), .o_ld_done(done_a), .o_cpu_hold(hold_a), .o_ld_ovf(ovf_a),
      .o_fetch_err(ferr_a));

   inst_mem_resp #(.DEPTH_LOG2(2), .BASE_ADDR(32'h100)) u_b (
      .i_clk(clk), .i_rst(rst), .i_rom_en(rom_en), .i_rom_addr(rom_addr), .o_rom_data(data_b),
      .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last),
      .o_ld_ready(rdy_b), .o_ld_done(done_b), .o_cpu_hold(hold_b), .o_ld_ovf(ovf_b),
      .o_fetch_err(ferr_b));

   int          n_chk = 0;
   int          n_fail = 0;
   logic [32:0] sbq[$];   // {on_b, expected rom_data}
   string       sbn[$];
   logic [32:0] m_e;
   string       m_n;
   logic        m_prev_done = 1'b0;
   logic [31:0] W [5];
   logic [31:0] P [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a fetch is presented; also polices ld_done width.
   always @(negedge clk) begin
      if (rom_en && sbq.size() > 0) begin
         m_e = sbq.pop_front();
         m_n = sbn.pop_front();
         chk(m_n, m_e[32] ? data_b : data_a, m_e[31:0]);
      end
      if (done_a) chk1("ld_done_width", m_prev_done, 1'b0);
      m_prev_done = done_a;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic put_beat(input logic [LW-1:0] d, input logic last);
      int n = 0;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      @(negedge clk);
      while (!rdy_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("ld_ready_wait", rdy_a, 1'b1);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] w, input logic last);
`ifdef INST_MEM_BYTE_LOAD_EN
      logic [31:0] t;
      t = w;
      put_beat(t[31:24], 1'b0);
      put_beat(t[23:16], 1'b0);
      put_beat(t[15:8], 1'b0);
      put_beat(t[7:0], last);
`else
      put_beat(w, last);
`endif
   endtask

   // Called right after the edge that accepted the last beat.
   task automatic chk_done(input string nm);
      chk1({nm, "_done"}, done_a, 1'b1);
      chk1({nm, "_hold"}, hold_a, 1'b0);
      chk1({nm, "_ready"}, rdy_a, 1'b0);
      tick();
      chk1({nm, "_done_fall"}, done_a, 1'b0);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input logic on_b, input string nm);
      rom_en   = 1'b1;
      rom_addr = a;
      sbq.push_back({on_b, exp});
      sbn.push_back(nm);
      tick();
      rom_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x3;
      for (int i = 0; i < 5; i++) begin
         W[i] = 32'h5000_0000 + 32'h0101_0011 * i;
         P[i] = 32'h7700_0000 + 32'h0000_1001 * i;
      end
      rst = 1'b1; rom_en = 1'b0; rom_addr = 32'h0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
      tick();
      tick();

      // 1: reset state
      chk1("rst_hold", hold_a, 1'b1);
      chk1("rst_ready", rdy_a, 1'b0);
      chk1("rst_done", done_a, 1'b0);
      chk1("rst_ovf", ovf_a, 1'b0);
      chk1("rst_ferr", ferr_a, 1'b0);
      fetch(32'h0, 32'h0, 1'b0, "rst_fetch");
      rst = 1'b0;
      ld_valid = 1'b1;
      tick();
      tick();
      chk1("idle_ready", rdy_a, 1'b0);
      ld_valid = 1'b0;
      fetch(32'h0, 32'h0, 1'b0, "idle_fetch");

      // 2: three-word load and fetch back
      start_load();
      chk1("load_hold", hold_a, 1'b1);
      put_word(32'h3401_0011, 1'b0);
      put_word(32'h3402_0022, 1'b0);
      put_word(32'h3403_0033, 1'b1);
      chk_done("t2");
      fetch(32'h0, 32'h3401_0011, 1'b0, "t2_w0");
      fetch(32'h4, 32'h3402_0022, 1'b0, "t2_w1");
      fetch(32'h8, 32'h3403_0033, 1'b0, "t2_w2");
      rom_en = 1'b1; rom_addr = 32'hC;
      tick();
      rom_en = 1'b0;
      chk1("t2_addr12_noerr", ferr_a, 1'b0);

      // 3: misaligned and out-of-range fetches
      fetch(32'h2, 32'h0, 1'b0, "t3_misal");
      chk1("t3_ferr_misal", ferr_a, 1'b1);
      fetch(32'h1000, 32'h0, 1'b0, "t3_oor");
      chk1("t3_ferr_sticky", ferr_a, 1'b1);
      fetch(32'h4, 32'h3402_0022, 1'b0, "t3_fetch_after_err");
      fetch(32'h108, 32'h3403_0033, 1'b1, "t3_b_base");
      chk1("t3_b_ferr_below_base", ferr_b, 1'b1);

      // 4: wrap on the 4-word instance
      start_load();
      chk1("t4_hold", hold_a, 1'b1);
      chk1("t4_ferr_clr_a", ferr_a, 1'b0);
      chk1("t4_ferr_clr_b", ferr_b, 1'b0);
      for (int i = 0; i < 5; i++) put_word(W[i], i == 4);
      chk1("t4_ovf_b", ovf_b, 1'b1);
      chk1("t4_ovf_a", ovf_a, 1'b0);
      chk_done("t4");
      fetch(32'h100, W[4], 1'b1, "t4_b0");
      fetch(32'h104, W[1], 1'b1, "t4_b1");
      fetch(32'h108, W[2], 1'b1, "t4_b2");
      fetch(32'h10C, W[3], 1'b1, "t4_b3");
      fetch(32'h110, 32'h0, 1'b1, "t4_b_oor");
      fetch(32'h0, W[0], 1'b0, "t4_a0");
      fetch(32'h10, W[4], 1'b0, "t4_a4");

      // 5: restart mid-load (with a valid beat on the restart cycle), then reset mid-load
      start_load();
      put_word(32'hDEAD_0001, 1'b0);
      put_word(32'hDEAD_0002, 1'b0);
      x3 = 32'hBAD0_BAD3;
      ld_start = 1'b1; ld_valid = 1'b1; ld_data = x3[LW-1:0];
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      put_word(32'hAAAA_0001, 1'b0);
      put_word(32'hBBBB_0002, 1'b1);
      chk1("t5_ovf_b_clr", ovf_b, 1'b0);
      chk_done("t5");
      fetch(32'h0, 32'hAAAA_0001, 1'b0, "t5_a0");
      fetch(32'h4, 32'hBBBB_0002, 1'b0, "t5_a1");
      fetch(32'h8, W[2], 1'b0, "t5_a2_kept");
      fetch(32'h108, W[2], 1'b1, "t5_b2_kept");

      start_load();
      for (int i = 0; i < 5; i++) put_word(P[i], 1'b0);
      chk1("t5_ovf_b_pre_rst", ovf_b, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("t5_rst_hold", hold_a, 1'b1);
      chk1("t5_rst_ready", rdy_a, 1'b0);
      chk1("t5_rst_ovf_b", ovf_b, 1'b0);
      chk1("t5_rst_done", done_a, 1'b0);
      fetch(32'h0, 32'h0, 1'b0, "t5_rst_idle_fetch");
      start_load();
      put_word(32'hC0DE_0000, 1'b1);
      chk_done("t5b");
      fetch(32'h0, 32'hC0DE_0000, 1'b0, "t5_new0");
      fetch(32'h4, P[1], 1'b0, "t5_partial1");
      fetch(32'h10, P[4], 1'b0, "t5_partial4");

`ifdef INST_MEM_BYTE_LOAD_EN
      // 6: byte assembly with a short final word
      start_load();
      put_beat(8'h24, 1'b0);
      put_beat(8'h01, 1'b0);
      put_beat(8'h00, 1'b0);
      put_beat(8'h05, 1'b0);
      put_beat(8'hAA, 1'b1);
      chk_done("t6");
      fetch(32'h0, 32'h2401_0005, 1'b0, "t6_w0");
      fetch(32'h4, 32'hAA00_0000, 1'b0, "t6_w1");
      fetch(32'h8, P[2], 1'b0, "t6_w2_kept");
`endif

      tick();
      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
